// File: rtl/bitstream_packer_arb.sv
// rtl/bitstream_packer_arb.sv - multi-source VLC bit packer with arbitration and flush
//
// Purpose:
//   Arbitrates NUM_CH variable-length code sources and packs the winning codes
//   MSB-first into an accumulator. It emits OUT_BYTES-wide words under backpressure.
//   A flush drains the accumulator and pads the tail to a byte boundary. The last
//   word of the flush is marked with out_last.
//
// Ports:
//   CLOCK        clock, all state updates on the rising edge
//   RESET        synchronous active-high reset
//   in_valid     per-channel code valid
//   in_ready     per-channel accept (one-hot or zero)
//   in_val       per-channel code, right-aligned, MAX_CODE_BITS each
//   in_size      per-channel code length, 6 bits each
//   in_flush     per-channel flush request, applied after that beat's code
//   out_valid    output word valid
//   out_ready    downstream accept
//   out_data     packed word, first bit at MSB
//   out_byte_en  valid bytes of out_data, MSB byte first
//   out_last     final word of a flush
//   flush_done   one-cycle pulse when a flush completes
//   bit_count    total accepted code bits since reset (wraps)
//   size_err     sticky flag: an accepted in_size exceeded MAX_CODE_BITS

module bitstream_packer_arb #(
  parameter int NUM_CH        = 3,
  parameter int MAX_CODE_BITS = 32,
  parameter int OUT_BYTES     = 4,
  parameter int ACC_BITS      = 64,
  parameter int ARB_MODE      = 0
) (
  input  logic                            CLOCK,
  input  logic                            RESET,
  input  logic [NUM_CH-1:0]               in_valid,
  output logic [NUM_CH-1:0]               in_ready,
  input  logic [NUM_CH*MAX_CODE_BITS-1:0] in_val,
  input  logic [NUM_CH*6-1:0]             in_size,
  input  logic [NUM_CH-1:0]               in_flush,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [8*OUT_BYTES-1:0]          out_data,
  output logic [OUT_BYTES-1:0]            out_byte_en,
  output logic                            out_last,
  output logic                            flush_done,
  output logic [31:0]                     bit_count,
  output logic                            size_err
);

  localparam int W      = 8 * OUT_BYTES;
  localparam int FILL_W = $clog2(ACC_BITS + 1);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [FILL_W-1:0] W_F        = FILL_W'(W);
  localparam logic [FILL_W-1:0] ACCEPT_MAX = FILL_W'(ACC_BITS - MAX_CODE_BITS);
  localparam logic [5:0]        MAX_SZ     = 6'(MAX_CODE_BITS);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_TAIL  = 2'd2;

  // Accumulator holds valid bits left-aligned; every bit below fill is zero,
  // so new codes can be OR-ed in and the tail word is already zero-padded.
  logic [ACC_BITS-1:0] acc;
  logic [FILL_W-1:0]   fill;
  logic [1:0]          state;
  logic [CH_W-1:0]     rr_ptr;

  logic [CH_W-1:0]          grant_idx;
  logic                     grant_any;
  logic [MAX_CODE_BITS-1:0] sel_val;
  logic [5:0]               sel_size_raw;
  logic                     sel_flush;
  logic                     size_over;
  logic [5:0]               size_c;
  logic                     can_accept;
  logic                     accept;
  logic                     out_fire;
  logic [FILL_W-1:0]        tail_bytes;
  logic [MAX_CODE_BITS-1:0] code_mask;
  logic [ACC_BITS-1:0]      code_ext;
  logic [ACC_BITS-1:0]      acc_sh;
  logic [FILL_W-1:0]        fill_base;
  logic [FILL_W:0]          sh;
  logic [ACC_BITS-1:0]      acc_next;
  logic [FILL_W-1:0]        fill_next;

  // Grant search runs from the highest candidate down so that the last hit,
  // which is the lowest index or the first channel at/after rr_ptr, wins.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (ARB_MODE == 1) begin
        if (in_valid[(int'(rr_ptr) + k) % NUM_CH]) begin
          grant_idx = CH_W'((int'(rr_ptr) + k) % NUM_CH);
          grant_any = 1'b1;
        end
      end else begin
        if (in_valid[k]) begin
          grant_idx = CH_W'(k);
          grant_any = 1'b1;
        end
      end
    end
  end

  assign sel_val      = in_val[grant_idx*MAX_CODE_BITS +: MAX_CODE_BITS];
  assign sel_size_raw = in_size[grant_idx*6 +: 6];
  assign sel_flush    = in_flush[grant_idx];
  assign size_over    = (sel_size_raw > MAX_SZ);
  assign size_c       = size_over ? MAX_SZ : sel_size_raw;

  // The fill threshold guarantees a maximum-length code always fits.
  assign can_accept = (state == ST_RUN) && (fill <= ACCEPT_MAX);
  assign accept     = can_accept && grant_any;
  assign in_ready   = accept ? (NUM_CH'(1) << grant_idx) : '0;

  always_comb begin
    out_valid = 1'b0;
    case (state)
      ST_RUN, ST_DRAIN: out_valid = (fill >= W_F);
      ST_TAIL:          out_valid = 1'b1;
      default:          out_valid = 1'b0;
    endcase
  end

  assign out_fire   = out_valid && out_ready;
  assign out_data   = acc[ACC_BITS-1 -: W];
  assign tail_bytes = (fill + FILL_W'(7)) >> 3;
  assign out_last   = (state == ST_TAIL) || ((state == ST_DRAIN) && (fill == W_F));

  always_comb begin
    out_byte_en = '0;
    if (out_valid) begin
      if (state == ST_TAIL) begin
        out_byte_en = ~({OUT_BYTES{1'b1}} >> tail_bytes);
      end else begin
        out_byte_en = {OUT_BYTES{1'b1}};
      end
    end
  end

  // Shifting by the full width yields zero, so a size of MAX_CODE_BITS
  // gives an all-ones mask and a size of 0 gives an empty mask.
  assign code_mask = ~({MAX_CODE_BITS{1'b1}} << size_c);
  assign code_ext  = {{(ACC_BITS-MAX_CODE_BITS){1'b0}}, sel_val & code_mask};

  // The output shift is applied first. A code accepted in the same cycle then
  // lands directly below the bits that remain after the shift.
  assign acc_sh = out_fire ? (acc << W) : acc;

  always_comb begin
    fill_base = fill;
    if (out_fire) begin
      fill_base = (state == ST_TAIL) ? '0 : (fill - W_F);
    end
  end

  assign sh = (FILL_W+1)'(ACC_BITS) - {1'b0, fill_base} - (FILL_W+1)'(size_c);

  assign acc_next  = accept ? (acc_sh | (code_ext << sh)) : acc_sh;
  assign fill_next = accept ? (fill_base + FILL_W'(size_c)) : fill_base;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      acc        <= '0;
      fill       <= '0;
      state      <= ST_RUN;
      rr_ptr     <= '0;
      flush_done <= 1'b0;
      bit_count  <= '0;
      size_err   <= 1'b0;
    end else begin
      acc        <= acc_next;
      fill       <= fill_next;
      flush_done <= 1'b0;

      if (accept) begin
        bit_count <= bit_count + 32'(size_c);
        if (size_over) begin
          size_err <= 1'b1;
        end
        rr_ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
      end

      case (state)
        ST_RUN: begin
          if (accept && sel_flush) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fill >= W_F) begin
            // A word of exactly W bits is the final word of the flush.
            if (out_fire && (fill == W_F)) begin
              state      <= ST_RUN;
              flush_done <= 1'b1;
            end
          end else if (fill == '0) begin
            state      <= ST_RUN;
            flush_done <= 1'b1;
          end else begin
            state <= ST_TAIL;
          end
        end
        ST_TAIL: begin
          if (out_fire) begin
            state      <= ST_RUN;
            flush_done <= 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_bitstream_packer_arb.sv
// tb/tb_bitstream_packer_arb.sv - directed self-checking bench for bitstream_packer_arb

module tb_bitstream_packer_arb;

  logic        clk = 1'b0;
  logic        rst;

  logic [2:0]  in_valid, in_ready, in_flush;
  logic [95:0] in_val;
  logic [17:0] in_size;
  logic        out_valid, out_ready, out_last, flush_done, size_err;
  logic [31:0] out_data, bit_count;
  logic [3:0]  out_byte_en;

  logic [2:0]  rr_in_valid, rr_in_ready, rr_in_flush;
  logic [95:0] rr_in_val;
  logic [17:0] rr_in_size;
  logic        rr_out_valid, rr_out_ready, rr_out_last, rr_flush_done, rr_size_err;
  logic [31:0] rr_out_data, rr_bit_count;
  logic [3:0]  rr_out_byte_en;

  int n_checks = 0;
  int n_pass   = 0;
  int fd_count = 0;

  logic [31:0] q_data[$];
  logic [3:0]  q_be[$];
  logic        q_last[$];

  logic [31:0] codes [6] = '{32'h01234567, 32'h89ABCDEF, 32'h0F1E2D3C,
                             32'h4B5A6978, 32'h8796A5B4, 32'hC3D2E1F0};
  logic [2:0]  rr_exp [4] = '{3'b001, 3'b100, 3'b001, 3'b100};

  bitstream_packer_arb #(.ARB_MODE(0)) dut (
    .CLOCK(clk), .RESET(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_val(in_val),
    .in_size(in_size), .in_flush(in_flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_byte_en(out_byte_en), .out_last(out_last), .flush_done(flush_done),
    .bit_count(bit_count), .size_err(size_err)
  );

  bitstream_packer_arb #(.ARB_MODE(1)) dut_rr (
    .CLOCK(clk), .RESET(rst),
    .in_valid(rr_in_valid), .in_ready(rr_in_ready), .in_val(rr_in_val),
    .in_size(rr_in_size), .in_flush(rr_in_flush),
    .out_valid(rr_out_valid), .out_ready(rr_out_ready), .out_data(rr_out_data),
    .out_byte_en(rr_out_byte_en), .out_last(rr_out_last), .flush_done(rr_flush_done),
    .bit_count(rr_bit_count), .size_err(rr_size_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_be.push_back(out_byte_en);
      q_last.push_back(out_last);
    end
    if (!rst && flush_done) fd_count++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_be.delete();
    q_last.delete();
  endtask

  task automatic send(input int ch, input logic [31:0] val, input logic [5:0] size,
                      input logic flush, input int budget);
    logic done;
    done = 1'b0;
    in_valid[ch]         = 1'b1;
    in_val[ch*32 +: 32]  = val;
    in_size[ch*6 +: 6]   = size;
    in_flush[ch]         = flush;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (in_ready[ch]) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid[ch] = 1'b0;
    in_flush[ch] = 1'b0;
    check($sformatf("send_ch%0d_accepted", ch), done, 1);
  endtask

  task automatic wait_beats(input string tag, input int n);
    for (int i = 0; i < 200 && q_data.size() < n; i++) begin
      @(negedge clk);
      #1;
    end
    check({tag, "_beats"}, q_data.size(), n);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int fd0;
    logic [31:0] hold;
    int changes;

    rst = 1'b1;
    in_valid = '0; in_val = '0; in_size = '0; in_flush = '0; out_ready = 1'b1;
    rr_in_valid = '0; rr_in_val = '0; rr_in_size = '0; rr_in_flush = '0; rr_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_byte_en", out_byte_en, 0);
    check("rst_bit_count", bit_count, 0);
    check("rst_size_err", size_err, 0);
    check("rst_flush_done", flush_done, 0);
    check("rst_in_ready", in_ready, 0);
    step();

    // four bytes on ch0 form one full word
    clear_q();
    send(0, 32'hDE, 6'd8, 1'b0, 50);
    send(0, 32'hAD, 6'd8, 1'b0, 50);
    send(0, 32'hBE, 6'd8, 1'b0, 50);
    send(0, 32'hEF, 6'd8, 1'b0, 50);
    wait_beats("t1", 1);
    if (q_data.size() >= 1) begin
      check("t1_data", q_data[0], 32'hDEADBEEF);
      check("t1_byte_en", q_be[0], 4'hF);
      check("t1_last", q_last[0], 0);
    end
    check("t1_bit_count", bit_count, 32);
    step();

    // 3-bit flush on ch1 becomes a one-byte tail word
    clear_q();
    fd0 = fd_count;
    send(1, 32'h5, 6'd3, 1'b1, 50);
    wait_beats("t2", 1);
    if (q_data.size() >= 1) begin
      check("t2_data", q_data[0], 32'hA0000000);
      check("t2_byte_en", q_be[0], 4'b1000);
      check("t2_last", q_last[0], 1);
    end
    repeat (4) @(negedge clk);
    #1;
    check("t2_flush_done_cycles", fd_count - fd0, 1);
    check("t2_bit_count", bit_count, 35);
    check("t2_idle_out_valid", out_valid, 0);
    step();

    // arbitration with ch0 and ch2 both valid, zero-size codes
    in_size = '0;
    rr_in_size = '0;
    in_valid = 3'b101;
    rr_in_valid = 3'b101;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("t3_fixed_%0d", i), in_ready, 3'b001);
      check($sformatf("t3_rr_%0d", i), rr_in_ready, rr_exp[i]);
    end
    step();
    in_valid = 3'b100;
    rr_in_valid = 3'b000;
    @(negedge clk);
    check("t3_fixed_ch2", in_ready, 3'b100);
    step();
    in_valid = '0;
    @(negedge clk);
    check("t3_bit_count", bit_count, 35);
    step();

    // backpressure: out_ready low while ch0 streams 32-bit codes
    clear_q();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(0, codes[i], 6'd32, 1'b0, 300);
      end
      begin
        repeat (3) @(negedge clk);
        hold = out_data;
        changes = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (out_data !== hold) changes++;
        end
        check("t4_stable", changes, 0);
        check("t4_hold_data", hold, codes[0]);
        check("t4_out_valid", out_valid, 1);
        check("t4_in_ready_low", in_ready[0], 0);
        check("t4_bit_count_stalled", bit_count, 99);
        step();
        out_ready = 1'b1;
      end
    join
    wait_beats("t4", 6);
    for (int i = 0; i < 6; i++) begin
      if (i < q_data.size()) check($sformatf("t4_word%0d", i), q_data[i], codes[i]);
    end
    check("t4_bit_count", bit_count, 227);
    step();

    // oversize code clamps to 32 bits and sets the sticky error
    check("t5_pre_size_err", size_err, 0);
    clear_q();
    send(0, 32'h12345678, 6'd40, 1'b0, 50);
    wait_beats("t5a", 1);
    if (q_data.size() >= 1) check("t5_data", q_data[0], 32'h12345678);
    check("t5_size_err", size_err, 1);
    check("t5_bit_count", bit_count, 259);
    step();
    clear_q();
    send(0, 32'h0BADF00D, 6'd32, 1'b0, 50);
    wait_beats("t5b", 1);
    if (q_data.size() >= 1) check("t5_data2", q_data[0], 32'h0BADF00D);
    check("t5_size_err_sticky", size_err, 1);
    check("t5_bit_count2", bit_count, 291);
    step();

    // reset while a tail word is stalled
    out_ready = 1'b0;
    send(0, 32'h5, 6'd4, 1'b1, 50);
    for (int i = 0; i < 20 && !out_last; i++) begin
      @(negedge clk);
      #1;
    end
    check("t6_tail_last", out_last, 1);
    check("t6_tail_valid", out_valid, 1);
    check("t6_tail_byte_en", out_byte_en, 4'b1000);
    check("t6_tail_data", out_data, 32'h50000000);
    check("t6_bit_count", bit_count, 295);
    fd0 = fd_count;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_out_last", out_last, 0);
    check("t6_rst_byte_en", out_byte_en, 0);
    check("t6_rst_bit_count", bit_count, 0);
    check("t6_rst_size_err", size_err, 0);
    step();
    out_ready = 1'b1;
    clear_q();
    send(0, 32'h11, 6'd8, 1'b0, 50);
    send(0, 32'h22, 6'd8, 1'b0, 50);
    send(0, 32'h33, 6'd8, 1'b0, 50);
    send(0, 32'h44, 6'd8, 1'b0, 50);
    wait_beats("t6", 1);
    if (q_data.size() >= 1) begin
      check("t6_post_data", q_data[0], 32'h11223344);
      check("t6_post_last", q_last[0], 0);
    end
    check("t6_no_flush_done", fd_count - fd0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
